ex_muldiv: RTL

Iterative RV32M multiply/divide unit in the EX stage. It sits directly downstream of the DEC→ALU pipeline register and consumes its registered operands (`dataAlu1`, `dataAlu2`) when the decoded instruction is an M-extension op. It raises a stall request to the hazard detect unit while it computes, then presents a one-cycle result to the ALU→MEM register. The base ALU handles every non-M op; this block stays idle for those.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_div_core.sv | 53 +++++
 rtl/ex_muldiv.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// funct3 encodings, FSM state type, datapath width and the special-case
// constants used by the divide corner cases.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MD_INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0] MD_ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Two's complement negate when neg is set, pass-through otherwise.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath for ex_muldiv. Works on unsigned magnitudes;
// the caller handles signs. One quotient bit is produced per step, the
// dividend shifts out of the quotient register MSB first while the
// quotient bits shift in from the bottom.
module muldiv_div_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN:0]   partRem;
    logic [XLEN-1:0] quoReg;
    logic [XLEN-1:0] dvsrReg;
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;
    logic            fits;
    logic [XLEN:0]   remNext;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {partRem, quoReg[XLEN-1]};
        trial   = shifted - {2'b00, dvsrReg};
        fits    = !trial[XLEN+1];
        remNext = fits ? trial[XLEN:0] : shifted[XLEN:0];
    end

    // Load fresh operands or retire one quotient bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            partRem <= '0;
            quoReg  <= '0;
            dvsrReg <= '0;
        end else if (load) begin
            partRem <= '0;
            quoReg  <= dividend;
            dvsrReg <= divisor;
        end else if (step) begin
            partRem <= remNext;
            quoReg  <= {quoReg[XLEN-2:0], fits};
        end
    end

    assign quotient  = quoReg;
    assign remainder = partRem[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage. Holds the pipeline
// through stallReq while iterating and pulses done for one cycle with the rd
// value on result. Divide-by-zero and signed overflow resolve without
// iteration. Optional build macro ex_muldiv_FAST_MUL_EN replaces the
// shift-add multiplier with a single registered multiply (one-cycle latency).
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mdOp,
    input  logic [XLEN-1:0] dataAlu1,
    input  logic [XLEN-1:0] dataAlu2,
    input  logic            flush,
    output logic            stallReq,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_t       state;
    logic [4:0]      cnt;
    logic [2:0]      opReg;
    logic            negRes;
    logic            useSpec;
    logic [XLEN-1:0] specVal;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] resultHold;
    logic [63:0]     prod;

    logic            isDiv;
    logic            aSigned;
    logic            bSigned;
    logic            aNeg;
    logic            bNeg;
    logic            divZero;
    logic            divOvf;
    logic            special;
    logic            fastMul;
    logic [XLEN-1:0] aAbs;
    logic [XLEN-1:0] bAbs;
    logic [XLEN-1:0] fastRes;
    logic [XLEN-1:0] specNext;

    logic [XLEN:0]   sum33;
    logic [63:0]     prodNext;
    logic [63:0]     fullProd;
    logic [XLEN-1:0] finalVal;

    logic            divLoad;
    logic            divStep;
    logic [XLEN-1:0] divQuo;
    logic [XLEN-1:0] divRem;

`ifdef ex_muldiv_FAST_MUL_EN
    logic [63:0] aExt;
    logic [63:0] bExt;
    logic [63:0] fastProd;

    // Single multiply of the 33-bit sign-extended operands, captured on entry to DONE.
    always_comb begin
        aExt     = {{32{aNeg}}, dataAlu1};
        bExt     = {{32{bNeg}}, dataAlu2};
        fastProd = aExt * bExt;
        fastMul  = !isDiv;
        fastRes  = (mdOp == MD_MUL) ? fastProd[31:0] : fastProd[63:32];
    end
`else
    assign fastMul = 1'b0;
    assign fastRes = '0;
`endif

    // Decode the incoming op: signedness, magnitudes and the no-iteration cases.
    always_comb begin
        isDiv    = mdOp[2];
        aSigned  = (mdOp == MD_MULH) || (mdOp == MD_MULHSU) || (mdOp == MD_DIV) || (mdOp == MD_REM);
        bSigned  = (mdOp == MD_MULH) || (mdOp == MD_DIV) || (mdOp == MD_REM);
        aNeg     = aSigned && dataAlu1[XLEN-1];
        bNeg     = bSigned && dataAlu2[XLEN-1];
        aAbs     = cond_neg(dataAlu1, aNeg);
        bAbs     = cond_neg(dataAlu2, bNeg);
        divZero  = isDiv && (dataAlu2 == '0);
        divOvf   = ((mdOp == MD_DIV) || (mdOp == MD_REM)) &&
                   (dataAlu1 == MD_INT_MIN) && (dataAlu2 == MD_ALL_ONES);
        special  = divZero || divOvf;
        specNext = fastRes;
        if (divZero) begin
            specNext = mdOp[1] ? dataAlu1 : MD_ALL_ONES;
        end else if (divOvf) begin
            specNext = mdOp[1] ? '0 : MD_INT_MIN;
        end
    end

    // One shift-add step: the upper half accumulates, the lower half holds the remaining multiplier bits.
    always_comb begin
        sum33    = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
        prodNext = {sum33, prod[31:1]};
    end

    // Sign fix-up and result selection for the op finishing in DONE.
    always_comb begin
        fullProd = negRes ? (64'd0 - prod) : prod;
        case (opReg)
            MD_MUL:                      finalVal = fullProd[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: finalVal = fullProd[63:32];
            MD_DIV, MD_DIVU:             finalVal = cond_neg(divQuo, negRes);
            default:                     finalVal = cond_neg(divRem, negRes);
        endcase
        if (useSpec) begin
            finalVal = specVal;
        end
    end

    assign divLoad = !rst && !flush && (state == ST_IDLE) && start && isDiv && !special;
    assign divStep = !flush && (state == ST_DIV);

    muldiv_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (divLoad),
        .step      (divStep),
        .dividend  (aAbs),
        .divisor   (bAbs),
        .quotient  (divQuo),
        .remainder (divRem)
    );

    // Main sequencer: accept ops in IDLE, iterate in MUL/DIV, present one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            opReg      <= '0;
            negRes     <= 1'b0;
            useSpec    <= 1'b0;
            specVal    <= '0;
            mcand      <= '0;
            prod       <= '0;
            resultHold <= '0;
        end else begin
            if (state == ST_DONE) begin
                resultHold <= finalVal;
            end
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            opReg   <= mdOp;
                            negRes  <= (isDiv && mdOp[1]) ? aNeg : (aNeg ^ bNeg);
                            useSpec <= special || fastMul;
                            specVal <= specNext;
                            mcand   <= aAbs;
                            prod    <= {32'd0, bAbs};
                            cnt     <= 5'd31;
                            if (special || fastMul) begin
                                state <= ST_DONE;
                            end else if (isDiv) begin
                                state <= ST_DIV;
                            end else begin
                                state <= ST_MUL;
                            end
                        end
                    end
                    ST_MUL: begin
                        prod <= prodNext;
                        if (cnt == 5'd0) begin
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                    ST_DIV: begin
                        if (cnt == 5'd0) begin
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign done     = (state == ST_DONE);
    assign result   = done ? finalVal : resultHold;
    assign stallReq = !rst && ((state == ST_MUL) || (state == ST_DIV) ||
                               ((state == ST_IDLE) && start && !special && !fastMul));

endmodule
